// File: rtl/chip8_multicycle_alu_if.sv
// Handshake bundle between the CPU operand fetch / write-back stages and the ALU.
// The master drives requests and consumes results; the slave is the ALU.
interface chip8_multicycle_alu_if #(
   parameter int WIDTH      = 8,
   parameter int BCD_DIGITS = 3
);
   logic                    in_valid;
   logic                    in_ready;
   logic [3:0]              op;
   logic [WIDTH-1:0]        a;
   logic [WIDTH-1:0]        b;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        result;
   logic                    flag;
   logic [4*BCD_DIGITS-1:0] bcd;
   logic                    busy;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, flag, bcd, busy
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, flag, bcd, busy
   );
endinterface

// File: rtl/chip8_multicycle_alu.sv
// Handshaked Chip-8 ALU: single-cycle logic/arith ops with VF flag, plus an
// iterative double-dabble binary-to-BCD mode for FX33.
module chip8_multicycle_alu #(
   parameter int WIDTH      = 8,
   parameter int BCD_DIGITS = 3
) (
   input logic                    clk,
   input logic                    reset,
   chip8_multicycle_alu_if.slave  bus
);
   localparam int BW = 4 * BCD_DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_BCD_RUN = 1'b1;

   localparam logic [3:0] OP_OR   = 4'd0;
   localparam logic [3:0] OP_AND  = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_SUBN = 4'd5;
   localparam logic [3:0] OP_SHR  = 4'd6;
   localparam logic [3:0] OP_SHL  = 4'd7;
   localparam logic [3:0] OP_EQ   = 4'd8;
   localparam logic [3:0] OP_GT   = 4'd9;
   localparam logic [3:0] OP_INC  = 4'd10;
   localparam logic [3:0] OP_BCD  = 4'd11;

   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   logic [0:0]       state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             flag_q, flag_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]    digits_q, digits_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             in_ready;
   logic             accept;
   logic [WIDTH-1:0] alu_res;
   logic             alu_flag;
   logic [WIDTH:0]   sum_ab;
   logic [BW-1:0]    digits_adj;
   logic [BW+WIDTH-1:0] dabble;

   assign in_ready = !reset && (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.flag      = flag_q;
   assign bus.bcd       = bcd_q;
   assign bus.busy      = (state_q == ST_BCD_RUN);

   // Double-dabble correction: any digit >= 5 gets +3 before the shift so it
   // carries correctly into the next decimal digit.
   generate
      for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_dabble
         assign digits_adj[4*gi +: 4] = (digits_q[4*gi +: 4] >= 4'd5)
                                       ? digits_q[4*gi +: 4] + 4'd3
                                       : digits_q[4*gi +: 4];
      end
   endgenerate

   assign dabble = {digits_adj, shift_q} << 1;
   assign sum_ab = {1'b0, bus.a} + {1'b0, bus.b};

   always_comb begin
      alu_res  = '0;
      alu_flag = 1'b0;
      case (bus.op)
         OP_OR:   alu_res = bus.a | bus.b;
         OP_AND:  alu_res = bus.a & bus.b;
         OP_XOR:  alu_res = bus.a ^ bus.b;
         OP_ADD: begin
            alu_res  = sum_ab[WIDTH-1:0];
            alu_flag = sum_ab[WIDTH];
         end
         OP_SUB: begin
            alu_res  = bus.a - bus.b;
            alu_flag = (bus.a >= bus.b);
         end
         OP_SUBN: begin
            alu_res  = bus.b - bus.a;
            alu_flag = (bus.b >= bus.a);
         end
         OP_SHR: begin
            alu_res  = bus.a >> 1;
            alu_flag = bus.a[0];
         end
         OP_SHL: begin
            alu_res  = bus.a << 1;
            alu_flag = bus.a[WIDTH-1];
         end
         OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
         OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (bus.a > bus.b)};
         OP_INC: begin
            alu_res  = bus.a + 1'b1;
            alu_flag = &bus.a;
         end
         default: begin
            alu_res  = '0;
            alu_flag = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flag_d      = flag_q;
      bcd_d       = bcd_q;
      shift_d     = shift_q;
      digits_d    = digits_q;
      cnt_d       = cnt_q;

      // Hand-off first; a completion on the same edge overrides it below.
      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (bus.op == OP_BCD) begin
                  shift_d  = bus.a;
                  digits_d = '0;
                  cnt_d    = CNT_INIT;
                  state_d  = ST_BCD_RUN;
               end else begin
                  out_valid_d = 1'b1;
                  result_d    = alu_res;
                  flag_d      = alu_flag;
                  bcd_d       = '0;
               end
            end
         end
         default: begin
            shift_d  = dabble[WIDTH-1:0];
            digits_d = dabble[BW+WIDTH-1:WIDTH];
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CNT_LAST) begin
               bcd_d       = dabble[BW+WIDTH-1:WIDTH];
               result_d    = '0;
               flag_d      = 1'b0;
               out_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flag_q      <= 1'b0;
         bcd_q       <= '0;
         shift_q     <= '0;
         digits_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flag_q      <= flag_d;
         bcd_q       <= bcd_d;
         shift_q     <= shift_d;
         digits_q    <= digits_d;
         cnt_q       <= cnt_d;
      end
   end
endmodule

// File: tb/tb_chip8_multicycle_alu.sv
// Randomised + directed bench for chip8_multicycle_alu with a transaction-level
// reference model checked on every cycle.
module tb_chip8_multicycle_alu;
   localparam int W = 8;
   localparam int D = 3;

   typedef struct packed {
      logic [W-1:0]   res;
      logic           flag;
      logic [4*D-1:0] bcd;
   } exp_t;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   chip8_multicycle_alu_if #(.WIDTH(W), .BCD_DIGITS(D)) bus ();

   chip8_multicycle_alu #(.WIDTH(W), .BCD_DIGITS(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned ai;
      int unsigned bi;
      exp_t e;
      ai = a;
      bi = b;
      e  = '0;
      case (op)
         4'd0:  e.res = a | b;
         4'd1:  e.res = a & b;
         4'd2:  e.res = a ^ b;
         4'd3:  begin e.res = W'((ai + bi) % 256); e.flag = (ai + bi) > 255; end
         4'd4:  begin e.res = W'(ai - bi); e.flag = (ai >= bi); end
         4'd5:  begin e.res = W'(bi - ai); e.flag = (bi >= ai); end
         4'd6:  begin e.res = W'(ai / 2); e.flag = (ai % 2) == 1; end
         4'd7:  begin e.res = W'(ai * 2); e.flag = (ai >= 128); end
         4'd8:  e.res = (ai == bi) ? 8'd1 : 8'd0;
         4'd9:  e.res = (ai > bi) ? 8'd1 : 8'd0;
         4'd10: begin e.res = W'(ai + 1); e.flag = (ai == 255); end
         4'd11: e.bcd = {4'(ai / 100), 4'((ai / 10) % 10), 4'(ai % 10)};
         default: e = '0;
      endcase
      return e;
   endfunction

   // Reference model: queue of pending results, BCD cycles remaining.
   exp_t pend_q[$];
   int   bcd_left = 0;

   always @(negedge clk) begin
      logic ev;
      logic er;
      if (reset) begin
         chk("in_ready_in_reset", bus.in_ready, 0);
         pend_q.delete();
         bcd_left = 0;
      end else begin
         ev = (pend_q.size() != 0) && (bcd_left == 0);
         er = (bcd_left == 0) && (!ev || bus.out_ready);
         chk("mdl_out_valid", bus.out_valid, ev);
         chk("mdl_busy", bus.busy, bcd_left != 0);
         chk("mdl_in_ready", bus.in_ready, er);
         if (ev) begin
            chk("mdl_result", bus.result, pend_q[0].res);
            chk("mdl_flag", bus.flag, pend_q[0].flag);
            chk("mdl_bcd", bus.bcd, pend_q[0].bcd);
            if (bus.out_ready) begin
               $display("txn out result=%h flag=%b bcd=%h", bus.result, bus.flag, bus.bcd);
               void'(pend_q.pop_front());
            end
         end
         if (bcd_left > 0) bcd_left--;
         if (bus.in_valid && er) begin
            pend_q.push_back(model(bus.op, bus.a, bus.b));
            if (bus.op == 4'd11) bcd_left = W;
         end
      end
   end

   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic ef, input logic [4*D-1:0] eb,
                         input string name);
      int n;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.op = op;
      bus.a  = a;
      bus.b  = b;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk({name, "_accept_timeout"}, 1, 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.out_valid && n < 50);
      chk({name, "_latency"}, n, (op == 4'd11) ? W + 1 : 1);
      chk({name, "_result"}, bus.result, er);
      chk({name, "_flag"}, bus.flag, ef);
      chk({name, "_bcd"}, bus.bcd, eb);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      logic [3:0] rop;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op        = '0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_flag", bus.flag, 0);
      chk("rst_bcd", bus.bcd, 0);
      chk("rst_busy", bus.busy, 0);

      run_op(4'd3,  8'hF0, 8'h20, 8'h10, 1'b1, 12'h000, "add_carry");
      run_op(4'd4,  8'h05, 8'h05, 8'h00, 1'b1, 12'h000, "sub_equal");
      run_op(4'd4,  8'h03, 8'h04, 8'hFF, 1'b0, 12'h000, "sub_borrow");
      run_op(4'd5,  8'h03, 8'h04, 8'h01, 1'b1, 12'h000, "subn");
      run_op(4'd6,  8'h81, 8'h00, 8'h40, 1'b1, 12'h000, "shr");
      run_op(4'd7,  8'h81, 8'h00, 8'h02, 1'b1, 12'h000, "shl");
      run_op(4'd10, 8'hFF, 8'h00, 8'h00, 1'b1, 12'h000, "inc_wrap");
      run_op(4'd11, 8'hFF, 8'h00, 8'h00, 1'b0, 12'h255, "bcd_255");
      run_op(4'd11, 8'h00, 8'h00, 8'h00, 1'b0, 12'h000, "bcd_0");
      run_op(4'd13, 8'h55, 8'hAA, 8'h00, 1'b0, 12'h000, "op_unused");

      // Back-pressure: result must hold and no new request may enter.
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.op = 4'd8; bus.a = 8'h12; bus.b = 8'h12;
      @(negedge clk);
      chk("bp_eq_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_result", bus.result, 8'h01);
         chk("bp_hold_in_ready", bus.in_ready, 0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.op = 4'd2; bus.a = 8'hF0; bus.b = 8'h0F;
      @(negedge clk);
      chk("bp_release_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("bp_xor_valid", bus.out_valid, 1);
      chk("bp_xor_result", bus.result, 8'hFF);

      // Streaming: one non-BCD op per cycle with no bubbles.
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
         do rop = 4'($urandom_range(0, 15)); while (rop == 4'd11);
         bus.in_valid = 1'b1;
         bus.op = rop;
         bus.a  = 8'($urandom);
         bus.b  = 8'($urandom);
         @(negedge clk);
         chk("stream_in_ready", bus.in_ready, 1);
         if (i > 0) chk("stream_no_bubble", bus.out_valid, 1);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("stream_last_valid", bus.out_valid, 1);

      // Random traffic with random back-pressure, BCD included.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         bus.in_valid  = ($urandom_range(0, 1) == 1);
         bus.op        = 4'($urandom_range(0, 15));
         bus.a         = 8'($urandom);
         bus.b         = 8'($urandom);
         bus.out_ready = ($urandom_range(0, 9) < 7);
      end
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (12) @(posedge clk);

      // Reset three cycles into a BCD conversion aborts it.
      #1;
      bus.in_valid = 1'b1;
      bus.op = 4'd11; bus.a = 8'd200; bus.b = 8'h00;
      @(negedge clk);
      chk("rstbcd_accept", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rstbcd_busy", bus.busy, 0);
      chk("rstbcd_out_valid", bus.out_valid, 0);
      chk("rstbcd_result", bus.result, 0);
      chk("rstbcd_flag", bus.flag, 0);
      chk("rstbcd_bcd", bus.bcd, 0);
      run_op(4'd0, 8'h0A, 8'h50, 8'h5A, 1'b0, 12'h000, "post_reset_or");

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/chip8_multicycle_alu.md
# chip8_multicycle_alu

Parametrised, handshaked successor to the CPU's combinational ALU. Executes one operation per accepted request on WIDTH-bit operands and produces a registered result plus a Chip-8-style flag (VF semantics) for the CPU's write-back. Adds an iterative binary-to-BCD mode (double-dabble) so the CPU can implement FX33 in hardware without a software loop. Sits between the Chip8_CPU operand fetch and register-file write-back, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 8, operand/result width; minimum 4.
- BCD_DIGITS, 3, BCD output digit count; must be at least ceil(WIDTH*log10(2)).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block accepts a request this cycle.
- op  in  4  operation code (see Operation).
- a  in  WIDTH  operand 1.
- b  in  WIDTH  operand 2; ignored by SHR, SHL, INC and BCD.
- out_valid  out  1  result/flag/bcd valid.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  operation result.
- flag  out  1  VF value for this operation.
- bcd  out  4*BCD_DIGITS  BCD digits, most significant digit in the top nibble; nonzero only for BCD.
- busy  out  1  BCD iteration in progress.

## Operation
- Op codes and results:
  - 0 OR: result a|b, flag 0.
  - 1 AND: result a&b, flag 0.
  - 2 XOR: result a^b, flag 0.
  - 3 ADD: result (a+b) mod 2^WIDTH, flag = carry out of bit WIDTH-1.
  - 4 SUB: result a-b mod 2^WIDTH, flag = 1 when a>=b (NOT borrow).
  - 5 SUBN: result b-a mod 2^WIDTH, flag = 1 when b>=a.
  - 6 SHR: result a>>1, flag = a[0].
  - 7 SHL: result a<<1 truncated to WIDTH bits, flag = a[WIDTH-1].
  - 8 EQ: result 1 when a==b, else 0 (zero-extended); flag 0.
  - 9 GT: result 1 when a>b (unsigned), else 0; flag 0.
  - 10 INC: result a+1 mod 2^WIDTH, flag = 1 when a is all ones.
  - 11 BCD: bcd = decimal digits of a (unsigned); result 0, flag 0.
  - 12–15: result 0, flag 0, bcd 0; completes as a single-cycle op.
- For every op other than BCD, bcd is 0.
- States:
  - IDLE: in_ready = !out_valid || out_ready.
    - An accepted non-BCD op loads result/flag/bcd and sets out_valid; the state stays IDLE.
    - An accepted BCD op loads the shift register with a and clears the digit accumulator. Iteration counter = WIDTH; go to BCD_RUN.
  - BCD_RUN: busy=1, in_ready=0. Each edge performs one iteration:
    - add 3 to every digit >= 5;
    - shift {digits, shift register} left by one;
    - decrement the counter.
  - On the edge where the counter reaches 0, load bcd, set out_valid and return to IDLE.
- Output registers hold steady while out_valid && !out_ready; they clear out_valid on an out_ready edge with no new completion.
- Reset: state IDLE, out_valid 0, result 0, flag 0, bcd 0, busy 0. in_ready is 0 in any cycle where reset is high.
- Reset during BCD_RUN aborts the conversion; no result is emitted.

## Timing
- Non-BCD latency: accepted at edge N gives out_valid high after edge N (visible in cycle N+1).
- Throughput is 1 op/cycle when out_ready is held high: accept and output hand-off can happen at the same edge.
- BCD latency: accepted at edge N, busy high for cycles N+1..N+WIDTH, out_valid high after edge N+WIDTH.
- When out_valid=1 and out_ready=0, in_ready=0: no overwrite, no loss.
- out_ready is ignored while out_valid=0.
- All outputs are registered except in_ready, which is combinational from state, out_valid, out_ready and reset.

## Test plan
- ADD/SUB/SUBN, WIDTH=8:
  - ADD a=0xF0, b=0x20 gives result 0x10, flag 1.
  - SUB a=0x05, b=0x05 gives result 0x00, flag 1.
  - SUB a=0x03, b=0x04 gives result 0xFF, flag 0.
  - SUBN a=0x03, b=0x04 gives result 0x01, flag 1.
- Shifts/INC:
  - SHR a=0x81 gives 0x40, flag 1.
  - SHL a=0x81 gives 0x02, flag 1.
  - INC a=0xFF gives 0x00, flag 1.
- BCD a=0xFF (255) gives bcd 0x255, result 0, busy for exactly 8 cycles, out_valid after edge N+8; in_ready 0 throughout. Also a=0 gives bcd 0x000.
- Back-pressure: issue EQ a=b=0x12 with out_ready=0 for 5 cycles.
  - result stays 0x01 and in_ready stays 0.
  - Then raise out_ready together with a pending XOR 0xF0^0x0F: the XOR is accepted at that edge and result 0xFF appears next cycle.
- Streaming: 16 random non-BCD ops with out_ready=1, one per cycle; every result matches the model with 1-cycle latency and no bubbles.
- Reset mid-BCD: assert reset 3 cycles into BCD a=200.
  - Next cycle: busy 0, out_valid 0, all outputs 0.
  - The following op (OR 0x0A|0x50) returns 0x5A normally.
